// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, total-derivation helpers and the RGB444 pixel type
// for the raster timing generator.
package vga_pkg;

    localparam int COL_W = 12;
    localparam int ROW_W = 11;

    // 1280x1024@60
    localparam int SXGA_H_ACTIVE = 1280;
    localparam int SXGA_H_FP     = 48;
    localparam int SXGA_H_SYNC   = 112;
    localparam int SXGA_H_BP     = 248;
    localparam int SXGA_V_ACTIVE = 1024;
    localparam int SXGA_V_FP     = 1;
    localparam int SXGA_V_SYNC   = 3;
    localparam int SXGA_V_BP     = 38;

    // 640x480@60
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster position/visibility to the renderers, renderer colour back in,
// and the registered VGA connector signals.
interface vga_timing_gen_if;

    logic [vga_pkg::COL_W-1:0] display_col;
    logic [vga_pkg::ROW_W-1:0] display_row;
    logic                      visible;
    logic                      frame_start;
    logic [3:0]                pix_red;
    logic [3:0]                pix_green;
    logic [3:0]                pix_blue;
    logic [3:0]                vga_r;
    logic [3:0]                vga_g;
    logic [3:0]                vga_b;
    logic                      vga_hs;
    logic                      vga_vs;

    modport master (
        output display_col, display_row, visible, frame_start,
        input  pix_red, pix_green, pix_blue,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

    modport slave (
        input  display_col, display_row, visible, frame_start,
        output pix_red, pix_green, pix_blue,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Resettable shift register aligning visibility/sync with the renderer latency.
// DEPTH of zero collapses to a wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator with delay-aligned, registered VGA sync and colour outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = SXGA_H_ACTIVE,
    parameter int H_FP       = SXGA_H_FP,
    parameter int H_SYNC     = SXGA_H_SYNC,
    parameter int H_BP       = SXGA_H_BP,
    parameter int V_ACTIVE   = SXGA_V_ACTIVE,
    parameter int V_FP       = SXGA_V_FP,
    parameter int V_SYNC     = SXGA_V_SYNC,
    parameter int V_BP       = SXGA_V_BP,
    parameter bit H_POL      = 1'b1,
    parameter bit V_POL      = 1'b1,
    parameter int PIPE_DELAY = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    vga_timing_gen_if.master bus
);

    localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COL_W-1:0] H_LAST   = COL_W'(H_TOT - 1);
    localparam logic [ROW_W-1:0] V_LAST   = ROW_W'(V_TOT - 1);
    localparam logic [COL_W-1:0] H_ACT_W  = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_ACT_W  = ROW_W'(V_ACTIVE);
    localparam logic [COL_W-1:0] HS_START = COL_W'(H_ACTIVE + H_FP);
    localparam logic [COL_W-1:0] HS_END   = COL_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [ROW_W-1:0] VS_START = ROW_W'(V_ACTIVE + V_FP);
    localparam logic [ROW_W-1:0] VS_END   = ROW_W'(V_ACTIVE + V_FP + V_SYNC);

    // r_h/r_v hold the position to be presented next, so the first edge out of
    // reset publishes (0,0) together with frame_start.
    logic [COL_W-1:0] r_h;
    logic [ROW_W-1:0] r_v;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_visible;
    logic             r_frame_start;
    logic             r_hs_raw;
    logic             r_vs_raw;
    logic [2:0]       w_dly;
    rgb444_t          w_pix;
    rgb444_t          r_rgb;
    logic             r_vga_hs;
    logic             r_vga_vs;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_h           <= '0;
            r_v           <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_visible     <= 1'b0;
            r_frame_start <= 1'b0;
            r_hs_raw      <= 1'b0;
            r_vs_raw      <= 1'b0;
        end else begin
            r_col         <= r_h;
            r_row         <= r_v;
            r_visible     <= (r_h < H_ACT_W) && (r_v < V_ACT_W);
            r_frame_start <= (r_h == '0) && (r_v == '0);
            r_hs_raw      <= (r_h >= HS_START) && (r_h < HS_END);
            r_vs_raw      <= (r_v >= VS_START) && (r_v < VS_END);
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Syncs travel active-high through the delay line so a cleared stage is inactive.
    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY)
    ) u_delay (
        .i_clk (i_clock),
        .i_rst (i_reset),
        .i_d   ({r_visible, r_hs_raw, r_vs_raw}),
        .o_q   (w_dly)
    );

    assign w_pix = {bus.pix_red, bus.pix_green, bus.pix_blue};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rgb    <= '0;
            r_vga_hs <= ~H_POL;
            r_vga_vs <= ~V_POL;
        end else begin
            r_rgb    <= w_dly[2] ? w_pix : '0;
            r_vga_hs <= ~(w_dly[1] ^ H_POL);
            r_vga_vs <= ~(w_dly[0] ^ V_POL);
        end
    end

    assign bus.display_col = r_col;
    assign bus.display_row = r_row;
    assign bus.visible     = r_visible;
    assign bus.frame_start = r_frame_start;
    assign bus.vga_r       = r_rgb.r;
    assign bus.vga_g       = r_rgb.g;
    assign bus.vga_b       = r_rgb.b;
    assign bus.vga_hs      = r_vga_hs;
    assign bus.vga_vs      = r_vga_vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances (delay 2 / positive sync,
// delay 0 / negative sync) checked cycle by cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int DA = 2;
    localparam int DB = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pix = '0;
    int          n = -1;
    int          pix_mode = 0;
    logic [11:0] hist[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();

    assign if_a.pix_red   = pix[11:8];
    assign if_a.pix_green = pix[7:4];
    assign if_a.pix_blue  = pix[3:0];
    assign if_b.pix_red   = pix[11:8];
    assign if_b.pix_green = pix[7:4];
    assign if_b.pix_blue  = pix[3:0];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(DA)
    ) u_a (.i_clock(clk), .i_reset(rst), .bus(if_a));

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(DB)
    ) u_b (.i_clock(clk), .i_reset(rst), .bus(if_b));

    // ---------------- reference model: cycle n counts from reset release ----------------
    function automatic int ecol(int k);  return k % HT;        endfunction
    function automatic int erow(int k);  return (k / HT) % VT; endfunction
    function automatic bit evis(int k);  return ecol(k) < HA && erow(k) < VA; endfunction
    function automatic bit efs(int k);   return ecol(k) == 0 && erow(k) == 0; endfunction
    function automatic bit ehs_raw(int k);
        return ecol(k) >= HA + HF && ecol(k) < HA + HF + HS;
    endfunction
    function automatic bit evs_raw(int k);
        return erow(k) >= VA + VF && erow(k) < VA + VF + VS;
    endfunction
    function automatic logic [11:0] ergb(int k, int d);
        if (k < d + 1) return 12'h000;
        return evis(k - d - 1) ? hist[k-1] : 12'h000;
    endfunction
    function automatic logic ehs(int k, int d, bit pol);
        if (k < d + 1) return !pol;
        return ehs_raw(k - d - 1) ? pol : !pol;
    endfunction
    function automatic logic evs(int k, int d, bit pol);
        if (k < d + 1) return !pol;
        return evs_raw(k - d - 1) ? pol : !pol;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        case (pix_mode)
            0:       pix = 12'($urandom_range(0, 4095));
            1:       pix = 12'hFFF;
            default: pix = (if_a.display_col == 12'(5 + DA)) ? 12'hF0A : 12'h000;
        endcase
        hist.push_back(pix);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        n = -1;
        hist.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (if_a.display_col !== 12'd0 || if_a.display_row !== 11'd0 ||
                if_a.visible !== 1'b0 || if_a.frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_raster_a: col=%0d row=%0d vis=%b fs=%b want 0/0/0/0",
                         if_a.display_col, if_a.display_row, if_a.visible, if_a.frame_start);
            end
            checks++;
            if ({if_a.vga_r, if_a.vga_g, if_a.vga_b} !== 12'h000 || if_a.vga_hs !== 1'b0 ||
                if_a.vga_vs !== 1'b0 || if_b.vga_hs !== 1'b1 || if_b.vga_vs !== 1'b1) begin
                errors++;
                $display("FAIL reset_vga: a rgb=%h hs=%b vs=%b b hs=%b vs=%b want 000/0/0 1/1",
                         {if_a.vga_r, if_a.vga_g, if_a.vga_b}, if_a.vga_hs, if_a.vga_vs,
                         if_b.vga_hs, if_b.vga_vs);
            end
        end
        release_reset();
        tick();
        checks++;
        if (if_a.display_col !== 12'd0 || if_a.display_row !== 11'd0 ||
            if_a.frame_start !== 1'b1 || if_a.visible !== 1'b1 ||
            if_b.frame_start !== 1'b1 || if_b.visible !== 1'b1) begin
            errors++;
            $display("FAIL first_cycle: col=%0d row=%0d fs=%b/%b vis=%b/%b want 0 0 1 1",
                     if_a.display_col, if_a.display_row, if_a.frame_start, if_b.frame_start,
                     if_a.visible, if_b.visible);
        end
        for (int k = 0; k <= DA; k++) begin
            if (k > 0) tick();
            checks++;
            if ({if_a.vga_r, if_a.vga_g, if_a.vga_b} !== 12'h000 ||
                if_a.vga_hs !== 1'b0 || if_a.vga_vs !== 1'b0) begin
                errors++;
                $display("FAIL post_release_blank: n=%0d rgb=%h hs=%b vs=%b want 000 0 0",
                         n, {if_a.vga_r, if_a.vga_g, if_a.vga_b}, if_a.vga_hs, if_a.vga_vs);
            end
        end
    endtask

    task automatic test_raster();
        int fs_seen = 0;
        repeat (2 * FR) begin
            tick();
            if (if_a.frame_start === 1'b1) fs_seen++;
            checks++;
            if (if_a.display_col !== 12'(ecol(n)) || if_a.display_row !== 11'(erow(n)) ||
                if_a.visible !== evis(n) || if_a.frame_start !== efs(n)) begin
                errors++;
                $display("FAIL raster_a: n=%0d col=%0d row=%0d vis=%b fs=%b want %0d %0d %b %b",
                         n, if_a.display_col, if_a.display_row, if_a.visible, if_a.frame_start,
                         ecol(n), erow(n), evis(n), efs(n));
            end
            checks++;
            if (if_b.display_col !== 12'(ecol(n)) || if_b.display_row !== 11'(erow(n)) ||
                if_b.visible !== evis(n) || if_b.frame_start !== efs(n)) begin
                errors++;
                $display("FAIL raster_b: n=%0d col=%0d row=%0d want %0d %0d",
                         n, if_b.display_col, if_b.display_row, ecol(n), erow(n));
            end
        end
        checks++;
        if (fs_seen != 2) begin
            errors++;
            $display("FAIL frame_start_count: got %0d want 2", fs_seen);
        end
    endtask

    task automatic test_sync();
        int hs_a = 0, vs_a = 0, hs_b = 0, vs_b = 0;
        repeat (FR) begin
            tick();
            if (if_a.vga_hs === 1'b1) hs_a++;
            if (if_a.vga_vs === 1'b1) vs_a++;
            if (if_b.vga_hs === 1'b0) hs_b++;
            if (if_b.vga_vs === 1'b0) vs_b++;
            checks++;
            if (if_a.vga_hs !== ehs(n, DA, 1'b1) || if_a.vga_vs !== evs(n, DA, 1'b1)) begin
                errors++;
                $display("FAIL sync_a: n=%0d hs=%b vs=%b want %b %b",
                         n, if_a.vga_hs, if_a.vga_vs, ehs(n, DA, 1'b1), evs(n, DA, 1'b1));
            end
            checks++;
            if (if_b.vga_hs !== ehs(n, DB, 1'b0) || if_b.vga_vs !== evs(n, DB, 1'b0)) begin
                errors++;
                $display("FAIL sync_b: n=%0d hs=%b vs=%b want %b %b",
                         n, if_b.vga_hs, if_b.vga_vs, ehs(n, DB, 1'b0), evs(n, DB, 1'b0));
            end
        end
        checks++;
        if (hs_a != HS * VT || hs_b != HS * VT || vs_a != VS * HT || vs_b != VS * HT) begin
            errors++;
            $display("FAIL sync_width: hs %0d/%0d vs %0d/%0d want %0d %0d",
                     hs_a, hs_b, vs_a, vs_b, HS * VT, VS * HT);
        end
    endtask

    task automatic test_pixels(input int mode);
        pix_mode = mode;
        repeat (FR) begin
            tick();
            checks++;
            if ({if_a.vga_r, if_a.vga_g, if_a.vga_b} !== ergb(n, DA)) begin
                errors++;
                $display("FAIL rgb_a mode%0d: n=%0d got %h want %h",
                         mode, n, {if_a.vga_r, if_a.vga_g, if_a.vga_b}, ergb(n, DA));
            end
            checks++;
            if ({if_b.vga_r, if_b.vga_g, if_b.vga_b} !== ergb(n, DB)) begin
                errors++;
                $display("FAIL rgb_b mode%0d: n=%0d got %h want %h",
                         mode, n, {if_b.vga_r, if_b.vga_g, if_b.vga_b}, ergb(n, DB));
            end
            // pixel for col 5 must surface three cycles after col 5 on visible rows
            if (mode == 2 && ecol(n) == 5 + DA + 1 && erow(n) < VA) begin
                checks++;
                if ({if_a.vga_r, if_a.vga_g, if_a.vga_b} !== 12'hF0A) begin
                    errors++;
                    $display("FAIL single_pixel: n=%0d got %h want f0a",
                             n, {if_a.vga_r, if_a.vga_g, if_a.vga_b});
                end
            end
        end
        pix_mode = 0;
    endtask

    task automatic test_reset_mid();
        int budget = 2 * FR;
        while (!(erow(n) == 5 && ecol(n) == 7) && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL mid_reset_reach: n=%0d never reached row 5 col 7", n);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (if_a.display_col !== 12'd0 || if_a.display_row !== 11'd0 ||
            if_a.vga_hs !== 1'b0 || if_b.vga_hs !== 1'b1 ||
            {if_a.vga_r, if_a.vga_g, if_a.vga_b} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset: col=%0d row=%0d hs=%b/%b rgb=%h want 0 0 0/1 000",
                     if_a.display_col, if_a.display_row, if_a.vga_hs, if_b.vga_hs,
                     {if_a.vga_r, if_a.vga_g, if_a.vga_b});
        end
        tick();
        release_reset();
        repeat (FR + 5) begin
            tick();
            checks++;
            if (if_a.display_col !== 12'(ecol(n)) || if_a.display_row !== 11'(erow(n)) ||
                if_a.frame_start !== efs(n) || if_a.vga_hs !== ehs(n, DA, 1'b1) ||
                if_a.vga_vs !== evs(n, DA, 1'b1) ||
                {if_a.vga_r, if_a.vga_g, if_a.vga_b} !== ergb(n, DA)) begin
                errors++;
                $display("FAIL after_mid_reset_a: n=%0d col=%0d row=%0d fs=%b hs=%b vs=%b rgb=%h",
                         n, if_a.display_col, if_a.display_row, if_a.frame_start,
                         if_a.vga_hs, if_a.vga_vs, {if_a.vga_r, if_a.vga_g, if_a.vga_b});
            end
            checks++;
            if (if_b.frame_start !== efs(n) || if_b.vga_hs !== ehs(n, DB, 1'b0) ||
                {if_b.vga_r, if_b.vga_g, if_b.vga_b} !== ergb(n, DB)) begin
                errors++;
                $display("FAIL after_mid_reset_b: n=%0d fs=%b hs=%b rgb=%h",
                         n, if_b.frame_start, if_b.vga_hs, {if_b.vga_r, if_b.vga_g, if_b.vga_b});
            end
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_sync();
        test_pixels(0);
        test_pixels(1);
        test_pixels(2);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
